ux607_irq_capture: RTL and testbench

Receiving end of the interrupt lines that the bench generator forces into the core. Synchronizes asynchronous interrupt inputs, records pending status (edge or level per line), arbitrates by fixed priority and offers one interrupt at a time to the core through a claim/complete handshake. A separate NMI path latches a rising edge and holds a request until it is acknowledged. The block sits between the interrupt sources (timer, software, external, NMI) and the core trap logic.

---
 rtl/ux607_irq_capture_pkg.sv | 20 ++
 rtl/ux607_irq_capture_if.sv | 49 ++++
 rtl/ux607_irq_sync.sv | 48 ++++
 rtl/ux607_irq_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_ux607_irq_capture.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ux607_irq_capture_pkg.sv
// ---------------------------------------------------------------------------
// ux607_irq_pkg
// Shared definitions for the ux607 interrupt capture block: FSM state
// encoding and default parameter values.
// ---------------------------------------------------------------------------
package ux607_irq_pkg;

  // Default number of maskable interrupt lines (ID = bit index).
  localparam int IRQ_NUM_DEF     = 16;
  // Default synchronizer depth per asynchronous input.
  localparam int SYNC_STAGES_DEF = 2;

  // Claim/complete handshake state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/ux607_irq_capture_if.sv
// ---------------------------------------------------------------------------
// ux607_irq_capture_if
// Claim/complete handshake between the interrupt capture block and the core.
//   master : capture block side (drives the offer, error pulse and active flag)
//   slave  : core side (drives accept and completion)
// Signals:
//   claim_valid    - an interrupt is offered
//   claim_id       - ID of the offered interrupt
//   claim_ready    - core accepts the offer
//   complete_valid - core finished servicing
//   complete_id    - ID being completed
//   complete_err   - one-cycle pulse on a bad completion
//   active         - an interrupt is in service
// ---------------------------------------------------------------------------
interface ux607_irq_capture_if
  import ux607_irq_pkg::*;
#(
  parameter int ID_W = $clog2(IRQ_NUM_DEF)
) ();

  logic            claim_valid;
  logic [ID_W-1:0] claim_id;
  logic            claim_ready;
  logic            complete_valid;
  logic [ID_W-1:0] complete_id;
  logic            complete_err;
  logic            active;

  modport master (
    output claim_valid,
    output claim_id,
    output complete_err,
    output active,
    input  claim_ready,
    input  complete_valid,
    input  complete_id
  );

  modport slave (
    input  claim_valid,
    input  claim_id,
    input  complete_err,
    input  active,
    output claim_ready,
    output complete_valid,
    output complete_id
  );

endinterface

// File: rtl/ux607_irq_sync.sv
// ---------------------------------------------------------------------------
// ux607_irq_sync
// Multi-flop synchronizer for one asynchronous input followed by a one-flop
// rising-edge detector.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   d_i       - raw asynchronous input
//   level_o   - synchronized level
//   rise_o    - one-cycle pulse on a synchronized 0->1 transition
// Parameters:
//   SYNC_STAGES - synchronizer depth, 2..3
// ---------------------------------------------------------------------------
module ux607_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;
  logic                   prev_q;
  logic                   prev_d;

  // Next state: shift the raw input in, remember the last synced level.
  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d_i};
    prev_d  = stage_q[SYNC_STAGES-1];
  end

  // Synchronizer chain and edge-history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {SYNC_STAGES{1'b0}};
      prev_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign level_o = stage_q[SYNC_STAGES-1];
  assign rise_o  = stage_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ux607_irq_capture.sv
// ---------------------------------------------------------------------------
// ux607_irq_capture
// Receives asynchronous interrupt lines, keeps per-line pending status (edge
// or level), picks the lowest eligible ID and offers it to the core through a
// claim/complete handshake. A separate NMI path latches a rising edge and
// holds the request until acknowledged.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   irq_i       - raw asynchronous interrupt lines
//   irq_edge_i  - per line: 1 = rising-edge triggered, 0 = level
//   irq_en_i    - per-line enable
//   bus         - claim/complete handshake (master side)
//   nmi_i       - raw asynchronous NMI
//   nmi_req_o   - NMI request, held until acknowledged
//   nmi_ack_i   - NMI acknowledge
// Build option:
//   UX607_IRQ_NMI_EN - when defined the NMI synchronizer, latch and handshake
//   are built; otherwise nmi_req_o is tied low and NMI inputs are ignored.
// ---------------------------------------------------------------------------
module ux607_irq_capture
  import ux607_irq_pkg::*;
#(
  parameter int IRQ_NUM     = IRQ_NUM_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int IRQ_ID_W    = $clog2(IRQ_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IRQ_NUM-1:0]  irq_i,
  input  logic [IRQ_NUM-1:0]  irq_edge_i,
  input  logic [IRQ_NUM-1:0]  irq_en_i,
  ux607_irq_capture_if.master bus,
  input  logic                nmi_i,
  output logic                nmi_req_o,
  input  logic                nmi_ack_i
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_OFFER  = ST_OFFER;
  localparam logic [1:0] S_ACTIVE = ST_ACTIVE;

  logic [IRQ_NUM-1:0]  level_s;
  logic [IRQ_NUM-1:0]  rise_s;
  logic [IRQ_NUM-1:0]  pend_s;
  logic [IRQ_NUM-1:0]  elig_s;
  logic [IRQ_NUM-1:0]  pend_edge_q;
  logic [IRQ_NUM-1:0]  pend_edge_d;
  logic [IRQ_ID_W-1:0] winner_s;
  logic                any_elig_s;
  logic                accept_s;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                claim_valid_q;
  logic                claim_valid_d;
  logic [IRQ_ID_W-1:0] claim_id_q;
  logic [IRQ_ID_W-1:0] claim_id_d;
  logic                active_q;
  logic                active_d;
  logic [IRQ_ID_W-1:0] inserv_id_q;
  logic [IRQ_ID_W-1:0] inserv_id_d;
  logic                complete_err_q;
  logic                complete_err_d;

  for (genvar g = 0; g < IRQ_NUM; g++) begin : g_sync
    ux607_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (irq_i[g]),
      .level_o (level_s[g]),
      .rise_o  (rise_s[g])
    );
  end

  assign accept_s = claim_valid_q & bus.claim_ready;

  // Pending status. Edge lines keep a sticky bit (a new edge beats the clear
  // on accept); level lines follow the synced level, masked while in service.
  always_comb begin
    pend_edge_d = {IRQ_NUM{1'b0}};
    pend_s      = {IRQ_NUM{1'b0}};
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (irq_edge_i[i]) begin
        pend_edge_d[i] = rise_s[i] |
                         (pend_edge_q[i] & ~(accept_s && (claim_id_q == IRQ_ID_W'(i))));
        pend_s[i]      = pend_edge_q[i];
      end else begin
        pend_edge_d[i] = 1'b0;
        pend_s[i]      = level_s[i] & ~(active_q && (inserv_id_q == IRQ_ID_W'(i)));
      end
    end
  end

  assign elig_s     = pend_s & irq_en_i;
  assign any_elig_s = |elig_s;

  // Fixed priority: lowest eligible ID wins (scan downwards, last hit sticks).
  always_comb begin
    winner_s = {IRQ_ID_W{1'b0}};
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      winner_s = elig_s[i] ? IRQ_ID_W'(i) : winner_s;
    end
  end

  // Claim/complete FSM next-state and output logic.
  always_comb begin
    state_d        = state_q;
    claim_valid_d  = claim_valid_q;
    claim_id_d     = claim_id_q;
    active_d       = active_q;
    inserv_id_d    = inserv_id_q;
    complete_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_elig_s) begin
          claim_valid_d = 1'b1;
          claim_id_d    = winner_s;
          state_d       = S_OFFER;
        end else begin
          state_d = S_IDLE;
        end
        // Nothing in service: any completion is an error.
        if (bus.complete_valid) begin
          complete_err_d = 1'b1;
        end else begin
          complete_err_d = 1'b0;
        end
      end
      S_OFFER: begin
        // The offer is frozen until accepted, whatever happens to the lines.
        if (bus.claim_ready) begin
          claim_valid_d = 1'b0;
          active_d      = 1'b1;
          inserv_id_d   = claim_id_q;
          state_d       = S_ACTIVE;
        end else begin
          state_d = S_OFFER;
        end
        if (bus.complete_valid) begin
          complete_err_d = 1'b1;
        end else begin
          complete_err_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (bus.complete_valid) begin
          if (bus.complete_id == inserv_id_q) begin
            active_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            complete_err_d = 1'b1;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      default: begin
        state_d       = S_IDLE;
        claim_valid_d = 1'b0;
        active_d      = 1'b0;
      end
    endcase
  end

  // Pending and FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_edge_q    <= {IRQ_NUM{1'b0}};
      state_q        <= S_IDLE;
      claim_valid_q  <= 1'b0;
      claim_id_q     <= {IRQ_ID_W{1'b0}};
      active_q       <= 1'b0;
      inserv_id_q    <= {IRQ_ID_W{1'b0}};
      complete_err_q <= 1'b0;
    end else begin
      pend_edge_q    <= pend_edge_d;
      state_q        <= state_d;
      claim_valid_q  <= claim_valid_d;
      claim_id_q     <= claim_id_d;
      active_q       <= active_d;
      inserv_id_q    <= inserv_id_d;
      complete_err_q <= complete_err_d;
    end
  end

  assign bus.claim_valid  = claim_valid_q;
  assign bus.claim_id     = claim_id_q;
  assign bus.active       = active_q;
  assign bus.complete_err = complete_err_q;

`ifdef UX607_IRQ_NMI_EN
  logic nmi_level_unused;
  logic nmi_rise_s;
  logic nmi_req_q;
  logic nmi_req_d;

  ux607_irq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_nmi_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (nmi_i),
    .level_o (nmi_level_unused),
    .rise_o  (nmi_rise_s)
  );

  // A new edge beats an acknowledge in the same cycle.
  always_comb begin
    nmi_req_d = nmi_rise_s | (nmi_req_q & ~nmi_ack_i);
  end

  // NMI request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_req_q <= 1'b0;
    end else begin
      nmi_req_q <= nmi_req_d;
    end
  end

  assign nmi_req_o = nmi_req_q;
`else
  logic nmi_unused;
  assign nmi_unused = nmi_i ^ nmi_ack_i;
  assign nmi_req_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_irq_capture.sv
// ---------------------------------------------------------------------------
// tb_ux607_irq_capture
// Directed bench: a per-cycle vector table for the basic edge and level
// flows, followed by hand-written sequences for the multi-cycle corners
// (held offer, bad completion, edge at accept, NMI, reset during offer).
// ---------------------------------------------------------------------------
module tb_ux607_irq_capture;
  import ux607_irq_pkg::*;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic [N-1:0] edg;
  logic [N-1:0] en;
  logic         nmi;
  logic         nmi_ack;
  logic         nmi_req;
  logic         exp_nmi;

  int n_checks = 0;
  int n_fail   = 0;

  ux607_irq_capture_if #(.ID_W(W)) bus ();

  ux607_irq_capture #(
    .IRQ_NUM     (N),
    .SYNC_STAGES (2),
    .IRQ_ID_W    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq),
    .irq_edge_i (edg),
    .irq_en_i   (en),
    .bus        (bus.master),
    .nmi_i      (nmi),
    .nmi_req_o  (nmi_req),
    .nmi_ack_i  (nmi_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] irq;
    logic [N-1:0] edg;
    logic [N-1:0] en;
    logic         rdy;
    logic         cval;
    logic [W-1:0] cid;
    logic         e_valid;
    logic [W-1:0] e_id;
    logic         e_act;
    logic         e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [N-1:0] i, input logic [N-1:0] e,
                              input logic r, input logic cv, input logic [W-1:0] ci,
                              input logic ev, input logic [W-1:0] eid,
                              input logic ea, input logic ee);
    vec_t v;
    v.irq = i; v.edg = e; v.en = 16'hFFFF; v.rdy = r; v.cval = cv; v.cid = ci;
    v.e_valid = ev; v.e_id = eid; v.e_act = ea; v.e_err = ee;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_offer(input int max_cyc, input string name);
    int k;
    k = 0;
    while ((bus.claim_valid !== 1'b1) && (k < max_cyc)) begin
      tick();
      k++;
    end
    check({name, "_offer"}, {31'd0, bus.claim_valid}, 32'd1);
  endtask

  initial begin
`ifdef UX607_IRQ_NMI_EN
    exp_nmi = 1'b1;
`else
    exp_nmi = 1'b0;
`endif
    // rows: irq, edge, ready, cval, cid -> valid, id, active, err
    vecs[0]  = mk(16'h0020, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[1]  = mk(16'h0020, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[2]  = mk(16'h0000, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[3]  = mk(16'h0000, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    vecs[4]  = mk(16'h0000, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    vecs[5]  = mk(16'h0000, 16'h0020, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[6]  = mk(16'h0000, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[7]  = mk(16'h0000, 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[8]  = mk(16'h0000, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[9]  = mk(16'h0000, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[10] = mk(16'h0208, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[11] = mk(16'h0208, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[12] = mk(16'h0208, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
    vecs[13] = mk(16'h0208, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[14] = mk(16'h0200, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[15] = mk(16'h0200, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[16] = mk(16'h0200, 16'h0000, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[17] = mk(16'h0200, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0);
    vecs[18] = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[19] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    vecs[20] = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[21] = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    vecs[22] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    rst = 1'b1; irq = '0; edg = '0; en = '0; nmi = 1'b0; nmi_ack = 1'b0;
    bus.claim_ready = 1'b0; bus.complete_valid = 1'b0; bus.complete_id = '0;
    tick(); tick();
    check("rst_valid", {31'd0, bus.claim_valid}, 32'd0);
    check("rst_id", {28'd0, bus.claim_id}, 32'd0);
    check("rst_active", {31'd0, bus.active}, 32'd0);
    check("rst_err", {31'd0, bus.complete_err}, 32'd0);
    check("rst_nmi", {31'd0, nmi_req}, 32'd0);
    rst = 1'b0;
    tick();

    // Vector table: edge line 5 flow, then level lines 3 and 9.
    for (int r = 0; r < NV; r++) begin
      irq = vecs[r].irq; edg = vecs[r].edg; en = vecs[r].en;
      bus.claim_ready = vecs[r].rdy; bus.complete_valid = vecs[r].cval;
      bus.complete_id = vecs[r].cid;
      tick();
      check($sformatf("v%0d_valid", r), {31'd0, bus.claim_valid}, {31'd0, vecs[r].e_valid});
      if (vecs[r].e_valid) begin
        check($sformatf("v%0d_id", r), {28'd0, bus.claim_id}, {28'd0, vecs[r].e_id});
      end
      check($sformatf("v%0d_active", r), {31'd0, bus.active}, {31'd0, vecs[r].e_act});
      check($sformatf("v%0d_err", r), {31'd0, bus.complete_err}, {31'd0, vecs[r].e_err});
    end
    irq = '0; bus.claim_ready = 1'b0; bus.complete_valid = 1'b0; bus.complete_id = '0;
    tick();

    // Held offer of 7 while higher-priority line 2 rises and enable drops.
    edg = '0; en = 16'hFFFF; irq = 16'h0080;
    wait_offer(8, "a");
    check("a_id", {28'd0, bus.claim_id}, 32'd7);
    irq = 16'h0084;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("a_hold_valid", {31'd0, bus.claim_valid}, 32'd1);
      check("a_hold_id", {28'd0, bus.claim_id}, 32'd7);
    end
    en = 16'hFF7F;
    tick();
    check("a_endrop_valid", {31'd0, bus.claim_valid}, 32'd1);
    check("a_endrop_id", {28'd0, bus.claim_id}, 32'd7);
    en = 16'hFFFF; irq = 16'h0004; bus.claim_ready = 1'b1;
    tick();
    check("a_accept_active", {31'd0, bus.active}, 32'd1);
    check("a_accept_valid", {31'd0, bus.claim_valid}, 32'd0);
    bus.claim_ready = 1'b0;
    tick(); tick();
    bus.complete_valid = 1'b1; bus.complete_id = 4'd7;
    tick();
    check("a_done_active", {31'd0, bus.active}, 32'd0);
    bus.complete_valid = 1'b0;
    tick();
    check("a_next_valid", {31'd0, bus.claim_valid}, 32'd1);
    check("a_next_id", {28'd0, bus.claim_id}, 32'd2);
    irq = '0; bus.claim_ready = 1'b1;
    tick();
    bus.claim_ready = 1'b0;
    tick(); tick();
    bus.complete_valid = 1'b1; bus.complete_id = 4'd2;
    tick();
    bus.complete_valid = 1'b0;
    tick(); tick();
    check("a_quiet_valid", {31'd0, bus.claim_valid}, 32'd0);

    // Mismatched completion while ID 6 is in service.
    edg = 16'h0040; irq = 16'h0040;
    tick(); tick();
    irq = '0;
    wait_offer(8, "b");
    check("b_id", {28'd0, bus.claim_id}, 32'd6);
    bus.claim_ready = 1'b1;
    tick();
    bus.claim_ready = 1'b0;
    check("b_active", {31'd0, bus.active}, 32'd1);
    bus.complete_valid = 1'b1; bus.complete_id = 4'd4;
    tick();
    check("b_err_pulse", {31'd0, bus.complete_err}, 32'd1);
    check("b_err_active", {31'd0, bus.active}, 32'd1);
    bus.complete_valid = 1'b0;
    tick();
    check("b_err_once", {31'd0, bus.complete_err}, 32'd0);
    check("b_still_active", {31'd0, bus.active}, 32'd1);
    bus.complete_valid = 1'b1; bus.complete_id = 4'd6;
    tick();
    bus.complete_valid = 1'b0;
    check("b_done_active", {31'd0, bus.active}, 32'd0);
    check("b_done_err", {31'd0, bus.complete_err}, 32'd0);

    // New edge on line 1 in the same cycle as accept of ID 1.
    edg = 16'h0002; irq = 16'h0002;
    tick(); tick();
    irq = '0;
    wait_offer(8, "c");
    check("c_id", {28'd0, bus.claim_id}, 32'd1);
    tick(); tick(); tick();
    irq = 16'h0002;
    tick(); tick();
    bus.claim_ready = 1'b1;
    tick();
    check("c_accept_active", {31'd0, bus.active}, 32'd1);
    bus.claim_ready = 1'b0; irq = '0;
    tick(); tick();
    bus.complete_valid = 1'b1; bus.complete_id = 4'd1;
    tick();
    bus.complete_valid = 1'b0;
    check("c_done_active", {31'd0, bus.active}, 32'd0);
    tick();
    check("c_reoffer_valid", {31'd0, bus.claim_valid}, 32'd1);
    check("c_reoffer_id", {28'd0, bus.claim_id}, 32'd1);
    bus.claim_ready = 1'b1;
    tick();
    bus.claim_ready = 1'b0;
    bus.complete_valid = 1'b1; bus.complete_id = 4'd1;
    tick();
    bus.complete_valid = 1'b0;
    tick(); tick();
    check("c_quiet_valid", {31'd0, bus.claim_valid}, 32'd0);

    // NMI edge with the acknowledge held off.
    nmi = 1'b1;
    tick(); tick();
    check("nmi_early", {31'd0, nmi_req}, 32'd0);
    tick();
    check("nmi_set", {31'd0, nmi_req}, {31'd0, exp_nmi});
    nmi = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("nmi_hold", {31'd0, nmi_req}, {31'd0, exp_nmi});
    end
    nmi_ack = 1'b1;
    tick();
    check("nmi_ack_clr", {31'd0, nmi_req}, 32'd0);
    nmi_ack = 1'b0;
    tick();
    check("nmi_stays_clr", {31'd0, nmi_req}, 32'd0);

    // Asynchronous reset while ID 4 is on offer.
    edg = '0; irq = 16'h0010;
    wait_offer(8, "e");
    check("e_id", {28'd0, bus.claim_id}, 32'd4);
    rst = 1'b1;
    #1;
    check("e_rst_valid", {31'd0, bus.claim_valid}, 32'd0);
    check("e_rst_id", {28'd0, bus.claim_id}, 32'd0);
    check("e_rst_active", {31'd0, bus.active}, 32'd0);
    check("e_rst_err", {31'd0, bus.complete_err}, 32'd0);
    check("e_rst_nmi", {31'd0, nmi_req}, 32'd0);
    irq = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("e_after_valid", {31'd0, bus.claim_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
